// File: rtl/neuron_pkg.sv
// neuron_pkg: shared constants, state encoding and spike event type for the
// Izhikevich neuron scheduler and update core (Q8.8 fixed point throughout).
package neuron_pkg;

  localparam int QW    = 16;  // Q8.8 word width
  localparam int QFRAC = 8;   // fractional bits

  localparam logic signed [QW-1:0] THRESHOLD = 16'sd1966;
  localparam int K_0_04 = 26;
  localparam int K_5    = 3276;
  localparam int K_140  = 9175;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, WRITE} state_e;

  // idx sized for the largest supported neuron count (16)
  typedef struct packed {
    logic [15:0] ts;
    logic [3:0]  idx;
  } spike_evt_t;

  // Resting recovery value u = (B*C)>>>8, truncated to Q8.8
  function automatic logic signed [QW-1:0] reset_u(input logic signed [QW-1:0] b,
                                                   input logic signed [QW-1:0] c);
    logic signed [31:0] b32, c32;
    b32 = b;
    c32 = c;
    return QW'((b32 * c32) >>> QFRAC);
  endfunction

endpackage

// File: rtl/neuron_scheduler_if.sv
// neuron_scheduler_if: spike event valid/ready bus from the scheduler FIFO
// head (master) to the spike router (slave).
interface neuron_scheduler_if #(
  parameter int N_NEURONS = 4
);
  localparam int IW = $clog2(N_NEURONS);

  logic          spike_valid;
  logic          spike_ready;
  logic [15:0]   spike_ts;
  logic [IW-1:0] spike_idx;

  modport master (output spike_valid, spike_ts, spike_idx, input spike_ready);
  modport slave  (input spike_valid, spike_ts, spike_idx, output spike_ready);
endinterface

// File: rtl/izh_update_core.sv
// izh_update_core: one combinational Izhikevich step in Q8.8. Intermediates
// are 32-bit signed (wrapping); v'/u' are truncated to 16 bits.
module izh_update_core
  import neuron_pkg::*;
(
  input  logic signed [QW-1:0] v,
  input  logic signed [QW-1:0] u,
  input  logic signed [QW-1:0] i_in,
  input  logic signed [QW-1:0] a,
  input  logic signed [QW-1:0] b,
  output logic signed [QW-1:0] v_n,
  output logic signed [QW-1:0] u_n,
  output logic                 spike
);
  logic signed [31:0] v32, u32, i32, a32, b32, vsq, dv, du;

  // Update equations, all in 32-bit signed arithmetic
  always_comb begin
    v32 = v;
    u32 = u;
    i32 = i_in;
    a32 = a;
    b32 = b;
    vsq = (v32 * v32) >>> QFRAC;
    dv  = (K_0_04 * vsq + K_5 * v32 + K_140 - u32 + i32) >>> 4;
    du  = (a32 * (((b32 * v32) >>> QFRAC) - u32)) >>> QFRAC;
  end

  assign v_n   = QW'(v32 + dv);
  assign u_n   = QW'(u32 + du);
  assign spike = (v_n >= THRESHOLD);
endmodule

// File: rtl/neuron_scheduler.sv
// neuron_scheduler: sweeps N_NEURONS virtual neurons through one shared
// update core per tick (LOAD/COMPUTE/WRITE per neuron) and queues spike
// events {ts, idx} in a first-word fall-through FIFO.
// Optional: define SCHED_OVERRUN_CNT_EN to build the saturating dropped-tick
// counter; otherwise overrun_cnt is tied to zero.
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int                 N_NEURONS  = 4,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic signed [15:0] A_PARAM    = 16'sd1311,
  parameter logic signed [15:0] B_PARAM    = 16'sd13107,
  parameter logic signed [15:0] C_PARAM    = -16'sd4259,
  parameter logic signed [15:0] D_PARAM    = 16'sd524
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [16*N_NEURONS-1:0] current,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [7:0]             overrun_cnt,
  neuron_scheduler_if.master     spk
);
  localparam int IW = $clog2(N_NEURONS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0]      LAST_IDX = IW'(N_NEURONS - 1);
  localparam logic signed [15:0] U_RST    = reset_u(B_PARAM, C_PARAM);

  state_e state, state_n;
  logic [IW-1:0] idx;
  logic [15:0]   ts;

  logic signed [15:0] v_arr [N_NEURONS];
  logic signed [15:0] u_arr [N_NEURONS];
  logic signed [15:0] snap  [N_NEURONS];

  logic signed [15:0] v_op, u_op, i_op, v_res, u_res, v_nxt, u_nxt;
  logic               spk_res, spk_nxt;

  spike_evt_t fifo [FIFO_DEPTH];
  spike_evt_t head;
  logic [PW:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop, commit, last, drop;

  assign busy  = (state != IDLE);
  assign last  = (idx == LAST_IDX);
  assign drop  = tick && (state != IDLE);
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = !empty && spk.spike_ready;

  izh_update_core u_core (
    .v    (v_op),
    .u    (u_op),
    .i_in (i_op),
    .a    (A_PARAM),
    .b    (B_PARAM),
    .v_n  (v_nxt),
    .u_n  (u_nxt),
    .spike(spk_nxt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state; WRITE commits only when a spike has FIFO room (a same-cycle pop counts)
  always_comb begin
    state_n = state;
    commit  = 1'b0;
    push    = 1'b0;
    unique case (state)
      IDLE:    if (tick) state_n = LOAD;
      LOAD:    state_n = COMPUTE;
      COMPUTE: state_n = WRITE;
      WRITE: begin
        if (!spk_res || !full || pop) begin
          commit  = 1'b1;
          push    = spk_res;
          state_n = last ? IDLE : LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Neuron state array, sweep index, timestep and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      ts      <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_arr[k] <= C_PARAM;
        u_arr[k] <= U_RST;
      end
    end else begin
      done <= commit && last;
      if (drop) overrun <= 1'b1;
      if (state == IDLE && tick) idx <= '0;
      if (commit) begin
        v_arr[idx] <= spk_res ? C_PARAM : v_res;
        u_arr[idx] <= spk_res ? u_res + D_PARAM : u_res;
        if (last) ts  <= ts + 16'd1;
        else      idx <= idx + 1'b1;
      end
    end
  end

  // Current snapshot and pipeline operand/result registers (no reset needed)
  always_ff @(posedge clk) begin
    if (state == IDLE && tick)
      for (int k = 0; k < N_NEURONS; k++) snap[k] <= current[16*k +: 16];
    if (state == LOAD) begin
      v_op <= v_arr[idx];
      u_op <= u_arr[idx];
      i_op <= snap[idx];
    end
    if (state == COMPUTE) begin
      v_res   <= v_nxt;
      u_res   <= u_nxt;
      spk_res <= spk_nxt;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= '{ts: ts, idx: 4'(idx)};
  end

  assign head            = fifo[rd_ptr[PW-1:0]];
  assign spk.spike_valid = !empty;
  assign spk.spike_ts    = head.ts;
  assign spk.spike_idx   = head.idx[IW-1:0];

  generate
    if (IW < 4) begin : g_idx_pad
      logic unused_idx_hi;
      assign unused_idx_hi = ^head.idx[3:IW];
    end
  endgenerate

`ifdef SCHED_OVERRUN_CNT_EN
  // Saturating count of ticks dropped while busy
  always_ff @(posedge clk) begin
    if (reset)                              overrun_cnt <= '0;
    else if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_neuron_scheduler.sv
// tb_neuron_scheduler: randomized bench with an array/queue reference model
// of the neuron sweep and spike event stream.
module tb_neuron_scheduler;
  localparam int N = 4;
  localparam int FD = 4;
  localparam int A = 1311, B = 13107, C = -4259, D = 524, THR = 1966;

  logic clk = 0;
  logic reset, tick;
  logic [16*N-1:0] current;
  logic busy, done, overrun;
  logic [7:0] overrun_cnt;
  logic rand_rdy = 0, rdy_cmd = 1, rnd_rdy = 1;

  neuron_scheduler_if #(.N_NEURONS(N)) spk();
  assign spk.spike_ready = rand_rdy ? rnd_rdy : rdy_cmd;

  neuron_scheduler #(.N_NEURONS(N), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .tick(tick), .current(current),
    .busy(busy), .done(done), .overrun(overrun), .overrun_cnt(overrun_cnt),
    .spk(spk)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int mv[N], mu[N], mts;
  int exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int s16(input int x);
    logic signed [15:0] t;
    t = x[15:0];
    return int'(t);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = C;
      mu[k] = s16((B * C) >>> 8);
    end
    mts = 0;
    exp_q.delete();
  endfunction

  function automatic void model_sweep(input logic [16*N-1:0] cur);
    int v, u, ii, vsq, vn, un;
    logic signed [15:0] t;
    for (int k = 0; k < N; k++) begin
      t = cur[16*k +: 16];
      ii = t; v = mv[k]; u = mu[k];
      vsq = (v * v) >>> 8;
      vn = s16(v + ((26 * vsq + 3276 * v + 9175 - u + ii) >>> 4));
      un = s16(u + ((A * (((B * v) >>> 8) - u)) >>> 8));
      if (vn >= THR) begin
        mv[k] = C;
        mu[k] = s16(un + D);
        exp_q.push_back((mts << 4) | k);
      end else begin
        mv[k] = vn;
        mu[k] = un;
      end
    end
    mts = (mts + 1) & 'hFFFF;
  endfunction

  // Every accepted event must match the model's next expected event
  always @(negedge clk) begin
    if (!reset && spk.spike_valid && spk.spike_ready) begin
      if (exp_q.size() == 0) chk("evt_unexpected", 1, 0);
      else begin
        int e;
        e = exp_q.pop_front();
        chk("evt_ts", int'(spk.spike_ts), e >> 4);
        chk("evt_idx", int'(spk.spike_idx), e & 15);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    rnd_rdy = ($urandom % 4) != 0;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cyc(); reset = 1; cyc(); cyc(); reset = 0;
    model_reset();
  endtask

  task automatic do_tick(input logic [16*N-1:0] cur);
    cyc(); current = cur; tick = 1; model_sweep(cur); cyc(); tick = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic chk_state();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("v%0d", k), int'(dut.v_arr[k]), mv[k]);
      chk($sformatf("u%0d", k), int'(dut.u_arr[k]), mu[k]);
    end
    chk("ts", int'(dut.ts), mts);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int nb, fb, dk, ovf, exp_cnt;
    logic [16*N-1:0] cur;
    reset = 1; tick = 0; current = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0); chk("rst_cnt", overrun_cnt, 0);
    chk("rst_valid", spk.spike_valid, 0);
    chk_state();

    // Sweep timing with zero current
    do_tick('0);
    nb = 0; fb = 0; dk = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) begin nb++; if (fb == 0) fb = k; end
      if (done && dk == 0) dk = k;
    end
    chk("busy_cycles", nb, 3 * N); chk("busy_first", fb, 1); chk("done_cycle", dk, 3 * N + 1);
    chk_state();

    // Lane 2 driven hard, periodic ticks
    cur = '0; cur[32 +: 16] = 16'h7FFF;
    for (int s = 0; s < 10; s++) begin
      do_tick(cur);
      wait_done(100, ok); chk("l2_done", ok, 1);
      chk_state();
      repeat (6) cyc();
    end
    repeat (10) cyc();
    chk("l2_drained", exp_q.size(), 0);

    // FIFO-full stall with consumer blocked
    rdy_cmd = 0;
    cur = {N{16'h7FFF}};
    for (int s = 0; s < 20; s++) begin
      do_tick(cur);
      if (exp_q.size() <= FD) begin
        wait_done(100, ok); chk("pre_stall_done", ok, 1); chk_state();
      end else begin
        ovf = exp_q.size() - FD;
        repeat (3 * N + 6) @(negedge clk);
        chk("stall_busy", busy, 1);
        chk("stall_valid", spk.spike_valid, 1);
        chk("stall_head_ts", int'(spk.spike_ts), exp_q[0] >> 4);
        chk("stall_head_idx", int'(spk.spike_idx), exp_q[0] & 15);
        cyc(); rdy_cmd = 1; cyc(); rdy_cmd = 0;
        if (ovf == 1) begin
          wait_done(3 * N + 6, ok); chk("stall_done", ok, 1);
          chk("stall_full_after", spk.spike_valid, 1);
        end
        cyc(); rdy_cmd = 1;
        if (ovf != 1) begin wait_done(300, ok); chk("stall_done_n", ok, 1); end
        chk_state();
        break;
      end
    end
    cyc(); rdy_cmd = 1;
    repeat (20) cyc();
    chk("stall_drained", exp_q.size(), 0);

    // Ticks at t, t+1, t+5: one sweep, two drops
    cyc(); current = '0; tick = 1; model_sweep('0);
    cyc(); cyc(); tick = 0;
    cyc(); cyc(); cyc(); tick = 1;
    cyc(); tick = 0;
    wait_done(100, ok); chk("ovr_done", ok, 1);
`ifdef SCHED_OVERRUN_CNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    chk("ovr_flag", overrun, 1); chk("ovr_cnt", overrun_cnt, exp_cnt);
    nb = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (busy) nb++; end
    chk("ovr_single_sweep", nb, 0);
    chk_state();

    // Reset in the middle of a sweep
    do_tick('0);
    repeat (5) cyc();
    reset = 1; cyc(); reset = 0;
    model_reset();
    @(negedge clk);
    chk("mrst_busy", busy, 0); chk("mrst_valid", spk.spike_valid, 0);
    chk("mrst_overrun", overrun, 0); chk("mrst_cnt", overrun_cnt, 0);
    chk_state();
    do_tick('0);
    wait_done(100, ok); chk("mrst_done", ok, 1);
    chk_state();

    // Random currents with a randomly stalling consumer
    rand_rdy = 1;
    for (int s = 0; s < 1000; s++) begin
      for (int k = 0; k < N; k++) cur[16*k +: 16] = 16'($urandom);
      do_tick(cur);
      wait_done(300, ok); chk("rnd_done", ok, 1);
      chk_state();
      repeat ($urandom_range(0, 3)) cyc();
    end
    cyc(); rand_rdy = 0; rdy_cmd = 1;
    repeat (40) cyc();
    @(negedge clk);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_empty", spk.spike_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/neuron_scheduler.md
# neuron_scheduler

Time-multiplexes one Izhikevich update datapath across `N_NEURONS` virtual neurons, holding each neuron's v/u state in internal registers. On every `tick` (one simulation timestep) it sweeps all neurons in index order: snapshot current, update, write back, reset on spike. Each spike is emitted as a {timestep, index} event through a small FIFO with valid/ready handshake. It sits between the stimulus/timebase logic and the spike router.

## Interface
- `N_NEURONS`, 4: number of virtual neurons; power of two, 2..16.
- `FIFO_DEPTH`, 4: spike event FIFO depth; power of two.
- `A_PARAM`/`B_PARAM`/`C_PARAM`/`D_PARAM`, 1311/13107/-4259/524: signed 16-bit Q8.8 model parameters, shared by all neurons.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: timestep strobe; one-cycle pulse.
- `current` in 16*N_NEURONS: signed Q8.8 input current; neuron i occupies bits [16i+15:16i].
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when a sweep completes.
- `overrun` out 1: sticky; set when `tick` arrives while busy.
- `overrun_cnt` out 8: saturating count of dropped ticks.
- `spike_valid` out 1: FIFO head valid.
- `spike_ready` in 1: consumer accepts head.
- `spike_ts` out 16: timestep number of head event.
- `spike_idx` out clog2(N_NEURONS): neuron index of head event.

## Operation
- Reset: every neuron v=C, u=(B*C)>>>8. FIFO empty. ts=0. State IDLE. busy=done=overrun=spike_valid=0. overrun_cnt=0.
- Reset mid-sweep aborts the sweep. No partial write-back survives, and no event is emitted.
- States:
  - IDLE: `tick` captures all `current` lanes into a snapshot, sets idx=0 and goes to LOAD.
  - LOAD: reads v[idx], u[idx] and snapshot[idx] into operand registers.
  - COMPUTE: registers the outputs of the update core.
  - WRITE: write back. If v' >= THRESHOLD (1966), store v=C and u=u'+D and push event {ts, idx}; otherwise store v', u'. If idx==N-1, go to IDLE, increment ts (wraps 0xFFFF->0) and pulse done; else idx+1 and go to LOAD.
- Spike when FIFO full: WRITE stalls and holds without committing until space exists. A pop in the same cycle counts as space, so a simultaneous push and pop at full is legal.
- Update arithmetic: all products are 32-bit signed; results are truncated to 16 bits (wrap, no saturation).
  - vsq = (v*v)>>>8
  - v' = v + ((26*vsq + 3276*v + 9175 - u + I)>>>4)
  - u' = u + ((A*(((B*v)>>>8) - u))>>>8)
- `tick` in any state other than IDLE is dropped. It sets `overrun` (cleared only by reset) and increments `overrun_cnt` (when enabled).
- `tick` on the same cycle that done pulses is accepted, because the state is then IDLE.
- FIFO: first-word fall-through. `spike_ts`/`spike_idx` are stable while `spike_valid && !spike_ready`.

## Timing
- `tick` sampled high at cycle t, with no stalls:
  - busy is high in cycles t+1 .. t+3N.
  - neuron k occupies LOAD/COMPUTE/WRITE in cycles t+1+3k / t+2+3k / t+3+3k.
  - done is high in cycle t+3N+1.
- The event for neuron k is visible on `spike_valid` in cycle t+4+3k (FIFO previously empty).
- Each FIFO-full stall cycle delays every later event and done by one cycle.
- ts increments at the edge ending the last WRITE. Events in a sweep carry the pre-increment value.

## Configuration
- `SCHED_OVERRUN_CNT_EN` defined: `overrun_cnt` is an 8-bit counter saturating at 255, incremented per dropped tick.
- Undefined: the counter is not built and `overrun_cnt` is tied to 0. The sticky `overrun` flag is unaffected.

## Structure
- Shared package `neuron_pkg`:
  - constants: THRESHOLD, K_0_04=26, K_5=3276, K_140=9175.
  - Q8.8 width localparams.
  - state enum typedef (IDLE/LOAD/COMPUTE/WRITE).
  - spike event struct {ts[15:0], idx}.
- Sub-module `izh_update_core`: purely combinational, (v,u,I,params) -> (v',u',spike). Reused by the future parallel engine.
- FIFO, snapshot and state array stay inline in the scheduler.

## Test plan
- Reset, then one tick with all currents 0 → busy high for exactly 12 cycles (N=4), done pulse at t+13, ts reads 1 after the sweep.
- current lane 2 = 16'sh7FFF, others 0, ticks every 20 cycles, spike_ready=1 → all events have idx=2; event ts values strictly increasing; neuron 2 state equals C after each spike sweep.
- All lanes 16'sh7FFF, spike_ready=0, tick until a sweep produces 5 spikes → FIFO holds 4 events; WRITE stalls with busy high; after one pop, the 5th event is enqueued and done follows.
- tick pulsed on cycles t, t+1, t+5 → one sweep only; overrun=1; overrun_cnt=2 with `SCHED_OVERRUN_CNT_EN`, 0 without.
- Assert reset at cycle t+6 of a sweep → next cycle busy=0, spike_valid=0, ts=0; the following tick produces a sweep identical to one from cold reset.
- Compare every WRITE against a reference model of the update equations, 1000 random-current ticks → bit-exact v/u/event match.
